exu_muldiv: RTL and testbench
=============================

# exu_muldiv

Iterative RV32M multiply/divide unit sitting beside the single-cycle ALU in the execute stage. It is parametrised in data width and in radix (bits retired per cycle). It accepts one operation per request handshake and computes it over multiple cycles. It presents the result on a valid/ready response channel, so the pipeline stalls the execute stage while `busy` is high. Operands arrive already forwarded. Flush from branch or trap aborts an in-flight operation.

## Interface
- `XLEN`, 32: operand and result width; must be even and ≥ 8.
- `BITS_PER_CYCLE`, 1: quotient/multiplier bits retired per CALC cycle; must divide `XLEN`. Allowed values are 1, 2 and 4.
- `clk`  in  1  clock; all state updates on the rising edge.
- `rstn`  in  1  asynchronous, active-low reset.
- `req_valid`  in  1  operation request.
- `req_ready`  out  1  unit can accept; equals (state == IDLE).
- `req_op`  in  3  RV32M funct3: 000 MUL, 001 MULH, 010 MULHSU, 011 MULHU, 100 DIV, 101 DIVU, 110 REM, 111 REMU.
- `req_rs1`  in  XLEN  forwarded rs1 operand (dividend or multiplicand).
- `req_rs2`  in  XLEN  forwarded rs2 operand (divisor or multiplier).
- `req_rd_idx`  in  5  destination register, carried to the response.
- `flush`  in  1  synchronous abort; highest priority.
- `resp_valid`  out  1  result available.
- `resp_ready`  in  1  consumer takes the result.
- `resp_data`  out  XLEN  result.
- `resp_rd_idx`  out  5  destination of the result.
- `busy`  out  1  state != IDLE; used by the hazard unit to stall IF/ID/EXE.

## Operation
- States: IDLE, CALC, DONE. The encoding is free.
- IDLE: `req_valid && req_ready && !flush` latches op, rd_idx, operand magnitudes and result-sign flags.
  - Signedness per op: MULH/DIV/REM treat both operands as signed. MULHSU treats rs1 as signed and rs2 as unsigned. The rest are unsigned.
  - If the op is divide-by-zero or signed overflow, go to DONE with the result precomputed. Otherwise go to CALC with counter = XLEN/BITS_PER_CYCLE.
- Special results (XLEN-wide):
  - Divide-by-zero: DIV/DIVU return all-ones; REM/REMU return rs1.
  - Signed overflow (rs1 = 1 followed by XLEN-1 zeros, rs2 = all-ones, DIV/REM only): DIV returns rs1; REM returns 0.
- CALC, multiply: shift-add on unsigned magnitudes into a 2·XLEN accumulator, BITS_PER_CYCLE multiplier bits per cycle. On exit, negate the 2·XLEN product if the sign flag is set. MUL takes the low XLEN bits; MULH/MULHSU/MULHU take the high XLEN bits.
- CALC, divide: restoring division on magnitudes, BITS_PER_CYCLE quotient bits per cycle. On exit, the quotient is negated if operand signs differ (signed ops). The remainder takes the dividend's sign.
- CALC decrements the counter each cycle. When the counter reaches 1, it loads `resp_data` and goes to DONE.
- DONE: `resp_valid`=1, with `resp_data` and `resp_rd_idx` held stable. `resp_ready` returns the unit to IDLE on the next edge. The unit does not accept a new request in the same cycle as the response handshake.
- `flush` in any state: next state IDLE and `resp_valid` drops next cycle. A request presented together with flush is not accepted.
- Reset (asynchronous): state IDLE, `resp_valid`=0, `resp_data`=0, `resp_rd_idx`=0, counter=0, accumulators=0. Consequently `req_ready`=1 and `busy`=0 during and after reset.
- Reset asserted mid-CALC discards the operation; no response appears.

## Timing
- Request accepted at edge T.
- Normal op, N = XLEN/BITS_PER_CYCLE:
  - CALC occupies cycles T+1 … T+N.
  - `resp_valid` is high from cycle T+N+1.
  - Total latency: 32+1 for the defaults; 8+1 for BITS_PER_CYCLE=4.
- Special case: `resp_valid` is high from cycle T+1.
- Response handshake at edge R: the unit is IDLE from R+1, so `req_ready` is high in cycle R+1.
- Throughput: at most one op every N+2 cycles.
- `busy` is combinational from state; it is high for the whole of CALC and DONE.
- No combinational path from `req_*` to `resp_*`.

## Test plan
- MUL 7 × 0xFFFFFFFD (defaults): `resp_data`=0xFFFFFFEB and `resp_valid` rises exactly 33 cycles after acceptance. MULH 0x80000000 × 0x80000000: 0x40000000. MULHSU 0xFFFFFFFF × 0xFFFFFFFF: 0xFFFFFFFF. MULHU same operands: 0xFFFFFFFE.
- DIV 0xFFFFFFF9 / 2 returns 0xFFFFFFFD, and REM returns 0xFFFFFFFF. DIVU 100 / 7 returns 14, and REMU returns 2. Repeat with BITS_PER_CYCLE=4: same results, latency 9.
- Special cases, each with `resp_valid` one cycle after acceptance:
  - DIV 5 / 0 returns 0xFFFFFFFF.
  - REMU 5 % 0 returns 5.
  - DIV 0x80000000 / 0xFFFFFFFF returns 0x80000000.
  - REM of the same operands returns 0.
- Backpressure: hold `resp_ready`=0 for 5 cycles in DONE. Data and rd_idx stay stable, while `req_ready`=0 and `busy`=1. Then pulse `resp_ready`: the unit goes IDLE next cycle and the next request is accepted.
- Flush at T+10 during CALC: no `resp_valid` ever appears and IDLE is reached at T+11. A request at T+11 completes correctly. A request presented together with flush in IDLE is not accepted.
- `rstn` pulsed low mid-CALC: all outputs go to their reset values immediately (asynchronously). After release, `req_ready`=1 and a fresh MUL 3 × 4 returns 12.

Source files
------------

// File: rtl/exu_muldiv.sv
// Iterative RV32M multiply/divide unit for the execute stage.
// Shift-add multiply and restoring divide on operand magnitudes, BITS_PER_CYCLE bits per step.
module exu_muldiv #(
    parameter int XLEN           = 32,
    parameter int BITS_PER_CYCLE = 1
) (
    input  logic            clk,
    input  logic            rstn,
    input  logic            req_valid,
    output logic            req_ready,
    input  logic [2:0]      req_op,
    input  logic [XLEN-1:0] req_rs1,
    input  logic [XLEN-1:0] req_rs2,
    input  logic [4:0]      req_rd_idx,
    input  logic            flush,
    output logic            resp_valid,
    input  logic            resp_ready,
    output logic [XLEN-1:0] resp_data,
    output logic [4:0]      resp_rd_idx,
    output logic            busy
);
    localparam int R  = BITS_PER_CYCLE;
    localparam int N  = XLEN / BITS_PER_CYCLE;
    localparam int CW = $clog2(N + 1);

    typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;
    state_t state, state_nxt;

    logic [2:0]        op_q;
    logic [CW-1:0]     cnt;
    logic [2*XLEN-1:0] acc;
    logic [XLEN-1:0]   opb;
    logic              neg_q;
    logic              neg_r;

    function automatic logic [XLEN-1:0] cneg(input logic [XLEN-1:0] v, input logic n);
        return n ? -v : v;
    endfunction

    function automatic logic [2*XLEN-1:0] cneg2(input logic [2*XLEN-1:0] v, input logic n);
        return n ? -v : v;
    endfunction

    logic            is_div;
    logic            sa;
    logic            sb;
    logic            div_zero;
    logic            sgn_ovf;
    logic            special;
    logic            accept;
    logic [XLEN-1:0] mag_a;
    logic [XLEN-1:0] mag_b;
    logic [XLEN-1:0] special_res;

    // Request decode: signedness, magnitudes and the two results known without iterating
    always_comb begin
        is_div   = req_op[2];
        sa       = req_rs1[XLEN-1] & (is_div ? ~req_op[0]
                                             : (req_op[1:0] == 2'b01 || req_op[1:0] == 2'b10));
        sb       = req_rs2[XLEN-1] & (is_div ? ~req_op[0] : (req_op[1:0] == 2'b01));
        mag_a    = cneg(req_rs1, sa);
        mag_b    = cneg(req_rs2, sb);
        div_zero = is_div && (req_rs2 == '0);
        sgn_ovf  = is_div && !req_op[0] && (req_rs1 == {1'b1, {(XLEN-1){1'b0}}})
                   && (req_rs2 == '1);
        special  = div_zero || sgn_ovf;
        if (div_zero) special_res = req_op[1] ? req_rs1 : '1;
        else          special_res = req_op[1] ? '0 : req_rs1;
    end

    assign req_ready  = (state == IDLE);
    assign busy       = (state != IDLE);
    assign resp_valid = (state == DONE);
    assign accept     = req_ready && req_valid && !flush;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) state <= IDLE;
        else       state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: if (req_valid && !flush) state_nxt = special ? DONE : CALC;
            CALC: if (cnt == CW'(1))       state_nxt = DONE;
            DONE: if (resp_ready)          state_nxt = IDLE;
            default:                       state_nxt = IDLE;
        endcase
        if (flush) state_nxt = IDLE;
    end

    logic [XLEN-1:0]   hi;
    logic [XLEN-1:0]   lo;
    logic [XLEN+R-1:0] sum;
    logic [XLEN:0]     rem;
    logic [XLEN-1:0]   q;
    logic [2*XLEN-1:0] acc_step;
    logic [2*XLEN-1:0] prod;
    logic [XLEN-1:0]   quo;
    logic [XLEN-1:0]   rem_o;
    logic [XLEN-1:0]   calc_res;

    // One CALC step: acc = {partial product | remainder, multiplier | dividend->quotient}
    always_comb begin
        hi  = acc[2*XLEN-1:XLEN];
        lo  = acc[XLEN-1:0];
        sum = {{R{1'b0}}, hi};
        for (int i = 0; i < R; i++) begin
            if (lo[i]) sum = sum + ({{R{1'b0}}, opb} << i);
        end
        rem = {1'b0, hi};
        q   = lo;
        for (int i = 0; i < R; i++) begin
            rem = {rem[XLEN-1:0], q[XLEN-1]};
            q   = {q[XLEN-2:0], 1'b0};
            if (rem >= {1'b0, opb}) begin
                rem  = rem - {1'b0, opb};
                q[0] = 1'b1;
            end
        end
        acc_step = op_q[2] ? {rem[XLEN-1:0], q} : {sum, lo[XLEN-1:R]};
        prod     = cneg2(acc_step, neg_q);
        quo      = acc_step[XLEN-1:0];
        rem_o    = acc_step[2*XLEN-1:XLEN];
        if (op_q[2]) calc_res = op_q[1] ? cneg(rem_o, neg_r) : cneg(quo, neg_q);
        else         calc_res = (op_q[1:0] == 2'b00) ? prod[XLEN-1:0] : prod[2*XLEN-1:XLEN];
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            op_q        <= '0;
            cnt         <= '0;
            acc         <= '0;
            opb         <= '0;
            neg_q       <= 1'b0;
            neg_r       <= 1'b0;
            resp_data   <= '0;
            resp_rd_idx <= '0;
        end else if (accept) begin
            op_q        <= req_op;
            resp_rd_idx <= req_rd_idx;
            neg_q       <= sa ^ sb;
            neg_r       <= sa;
            if (is_div) begin
                acc <= {{XLEN{1'b0}}, mag_a};
                opb <= mag_b;
            end else begin
                acc <= {{XLEN{1'b0}}, mag_b};
                opb <= mag_a;
            end
            if (special) begin
                cnt       <= '0;
                resp_data <= special_res;
            end else begin
                cnt <= CW'(N);
            end
        end else if (state == CALC && !flush) begin
            acc <= acc_step;
            cnt <= cnt - 1'b1;
            if (cnt == CW'(1)) resp_data <= calc_res;
        end
    end

endmodule

// File: tb/tb_exu_muldiv.sv
// Scoreboard bench for exu_muldiv: unit 0 at one bit per cycle, unit 1 at four.
module tb_exu_muldiv;
    localparam logic [2:0] MUL = 3'b000, MULH = 3'b001, MULHSU = 3'b010, MULHU = 3'b011;
    localparam logic [2:0] DIV = 3'b100, DIVU = 3'b101, REM = 3'b110, REMU = 3'b111;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rstn;
    logic        req_valid   [2];
    logic        req_ready   [2];
    logic [2:0]  req_op      [2];
    logic [31:0] req_rs1     [2];
    logic [31:0] req_rs2     [2];
    logic [4:0]  req_rd_idx  [2];
    logic        flush       [2];
    logic        resp_valid  [2];
    logic        resp_ready  [2];
    logic [31:0] resp_data   [2];
    logic [4:0]  resp_rd_idx [2];
    logic        busy        [2];

    for (genvar g = 0; g < 2; g++) begin : g_dut
        exu_muldiv #(.XLEN(32), .BITS_PER_CYCLE(g == 0 ? 1 : 4)) dut (
            .clk         (clk),
            .rstn        (rstn),
            .req_valid   (req_valid[g]),
            .req_ready   (req_ready[g]),
            .req_op      (req_op[g]),
            .req_rs1     (req_rs1[g]),
            .req_rs2     (req_rs2[g]),
            .req_rd_idx  (req_rd_idx[g]),
            .flush       (flush[g]),
            .resp_valid  (resp_valid[g]),
            .resp_ready  (resp_ready[g]),
            .resp_data   (resp_data[g]),
            .resp_rd_idx (resp_rd_idx[g]),
            .busy        (busy[g])
        );
    end

    typedef struct {
        int          u;
        logic [31:0] d;
        logic [4:0]  rd;
        int          lat;
        int          t0;
    } exp_t;

    exp_t exp_q[$];
    int   checks = 0;
    int   errors = 0;
    int   cyc    = 0;
    bit   prev_v [2];

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h, required %h", name, act, exp);
        end
    endtask

    // Monitor: every cycle a response is presented it must match the head of the scoreboard
    always @(negedge clk) begin
        for (int u = 0; u < 2; u++) begin
            if (!rstn) begin
                prev_v[u] = 1'b0;
            end else begin
                if (resp_valid[u]) begin
                    if (exp_q.size() == 0 || exp_q[0].u != u) begin
                        checks++;
                        errors++;
                        $display("FAIL unexpected_resp: unit %0d got data %h, required no response",
                                 u, resp_data[u]);
                    end else begin
                        if (!prev_v[u])
                            chk("latency", 32'(cyc - exp_q[0].t0), 32'(exp_q[0].lat));
                        chk("resp_data", resp_data[u], exp_q[0].d);
                        chk("resp_rd_idx", 32'(resp_rd_idx[u]), 32'(exp_q[0].rd));
                        chk("busy_in_done", 32'(busy[u]), 32'd1);
                        chk("req_ready_in_done", 32'(req_ready[u]), 32'd0);
                        if (resp_ready[u]) void'(exp_q.pop_front());
                    end
                end
                prev_v[u] = resp_valid[u];
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input int u, input logic [2:0] op, input logic [31:0] a,
                        input logic [31:0] b, input logic [4:0] rd,
                        input logic [31:0] expd, input int lat, input bit push);
        int n = 0;
        req_valid[u]  = 1'b1;
        req_op[u]     = op;
        req_rs1[u]    = a;
        req_rs2[u]    = b;
        req_rd_idx[u] = rd;
        while (!req_ready[u] && n < 100) begin
            step();
            n++;
        end
        if (!req_ready[u]) begin
            checks++;
            errors++;
            $display("FAIL req_ready_timeout: unit %0d req_ready %b, required 1", u, req_ready[u]);
        end
        if (push) exp_q.push_back('{u: u, d: expd, rd: rd, lat: lat, t0: cyc});
        step();
        req_valid[u] = 1'b0;
    endtask

    task automatic wait_done(input string name);
        int n = 0;
        while (exp_q.size() != 0 && n < 200) begin
            step();
            n++;
        end
        if (exp_q.size() != 0) begin
            checks++;
            errors++;
            $display("FAIL %s_timeout: %0d responses outstanding, required 0", name, exp_q.size());
            exp_q.delete();
        end
    endtask

    task automatic run(input string name, input int u, input logic [2:0] op,
                       input logic [31:0] a, input logic [31:0] b, input logic [4:0] rd,
                       input logic [31:0] expd, input int lat);
        send(u, op, a, b, rd, expd, lat, 1'b1);
        wait_done(name);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int c;
        int n;
        rstn = 1'b0;
        for (int u = 0; u < 2; u++) begin
            req_valid[u]  = 1'b0;
            req_op[u]     = 3'b000;
            req_rs1[u]    = '0;
            req_rs2[u]    = '0;
            req_rd_idx[u] = '0;
            flush[u]      = 1'b0;
            resp_ready[u] = 1'b1;
        end
        #3;
        for (int u = 0; u < 2; u++) begin
            chk("reset_req_ready", 32'(req_ready[u]), 32'd1);
            chk("reset_busy", 32'(busy[u]), 32'd0);
            chk("reset_resp_valid", 32'(resp_valid[u]), 32'd0);
            chk("reset_resp_data", resp_data[u], 32'd0);
        end
        step();
        step();
        rstn = 1'b1;
        step();

        run("mul",    0, MUL,    32'd7,        32'hFFFFFFFD, 5'd1,  32'hFFFFFFEB, 33);
        run("mulh",   0, MULH,   32'h80000000, 32'h80000000, 5'd2,  32'h40000000, 33);
        run("mulhsu", 0, MULHSU, 32'hFFFFFFFF, 32'hFFFFFFFF, 5'd3,  32'hFFFFFFFF, 33);
        run("mulhu",  0, MULHU,  32'hFFFFFFFF, 32'hFFFFFFFF, 5'd4,  32'hFFFFFFFE, 33);
        run("div",    0, DIV,    32'hFFFFFFF9, 32'd2,        5'd5,  32'hFFFFFFFD, 33);
        run("rem",    0, REM,    32'hFFFFFFF9, 32'd2,        5'd6,  32'hFFFFFFFF, 33);
        run("divu",   0, DIVU,   32'd100,      32'd7,        5'd7,  32'd14,       33);
        run("remu",   0, REMU,   32'd100,      32'd7,        5'd8,  32'd2,        33);
        run("div0",   0, DIV,    32'd5,        32'd0,        5'd9,  32'hFFFFFFFF, 1);
        run("remu0",  0, REMU,   32'd5,        32'd0,        5'd10, 32'd5,        1);
        run("divovf", 0, DIV,    32'h80000000, 32'hFFFFFFFF, 5'd11, 32'h80000000, 1);
        run("removf", 0, REM,    32'h80000000, 32'hFFFFFFFF, 5'd12, 32'd0,        1);

        run("r4_div",  1, DIV,  32'hFFFFFFF9, 32'd2,        5'd13, 32'hFFFFFFFD, 9);
        run("r4_rem",  1, REM,  32'hFFFFFFF9, 32'd2,        5'd14, 32'hFFFFFFFF, 9);
        run("r4_divu", 1, DIVU, 32'd100,      32'd7,        5'd15, 32'd14,       9);
        run("r4_remu", 1, REMU, 32'd100,      32'd7,        5'd16, 32'd2,        9);
        run("r4_mul",  1, MUL,  32'd7,        32'hFFFFFFFD, 5'd17, 32'hFFFFFFEB, 9);
        run("r4_div0", 1, DIV,  32'd5,        32'd0,        5'd18, 32'hFFFFFFFF, 1);

        // Backpressure: response held for five extra cycles, then released
        resp_ready[0] = 1'b0;
        send(0, DIVU, 32'd1000, 32'd10, 5'd19, 32'd100, 33, 1'b1);
        n = 0;
        while (!resp_valid[0] && n < 100) begin
            step();
            n++;
        end
        chk("bp_resp_valid_seen", 32'(resp_valid[0]), 32'd1);
        repeat (5) step();
        resp_ready[0] = 1'b1;
        step();
        chk("bp_req_ready_after", 32'(req_ready[0]), 32'd1);
        chk("bp_resp_valid_after", 32'(resp_valid[0]), 32'd0);
        run("bp_next", 0, REMU, 32'd1000, 32'd7, 5'd20, 32'd6, 33);

        // Flush ten cycles into CALC, then a request in the first idle cycle
        c = cyc;
        send(0, MUL, 32'd5, 32'd6, 5'd21, 32'd0, 0, 1'b0);
        while (cyc < c + 10) step();
        flush[0] = 1'b1;
        step();
        flush[0] = 1'b0;
        chk("flush_req_ready", 32'(req_ready[0]), 32'd1);
        chk("flush_busy", 32'(busy[0]), 32'd0);
        run("after_flush", 0, MUL, 32'd5, 32'd6, 5'd22, 32'd30, 33);

        // Request together with flush in IDLE must be dropped
        req_valid[0]  = 1'b1;
        req_op[0]     = MUL;
        req_rs1[0]    = 32'd9;
        req_rs2[0]    = 32'd9;
        req_rd_idx[0] = 5'd23;
        flush[0]      = 1'b1;
        step();
        req_valid[0] = 1'b0;
        flush[0]     = 1'b0;
        chk("flush_req_dropped_ready", 32'(req_ready[0]), 32'd1);
        chk("flush_req_dropped_busy", 32'(busy[0]), 32'd0);
        repeat (3) step();

        // Asynchronous reset in the middle of CALC
        send(0, MUL, 32'd123, 32'd456, 5'd24, 32'd0, 0, 1'b0);
        repeat (5) step();
        chk("pre_reset_busy", 32'(busy[0]), 32'd1);
        #2;
        rstn = 1'b0;
        #1;
        chk("arst_resp_valid", 32'(resp_valid[0]), 32'd0);
        chk("arst_busy", 32'(busy[0]), 32'd0);
        chk("arst_req_ready", 32'(req_ready[0]), 32'd1);
        chk("arst_resp_data", resp_data[0], 32'd0);
        chk("arst_resp_rd_idx", 32'(resp_rd_idx[0]), 32'd0);
        step();
        rstn = 1'b1;
        step();
        chk("post_reset_req_ready", 32'(req_ready[0]), 32'd1);
        run("post_reset_mul", 0, MUL, 32'd3, 32'd4, 5'd25, 32'd12, 33);
        repeat (3) step();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
